// File: rtl/pc_stack_if.sv
// pc_stack_if: control-unit to PC/stack-unit bundle.
// stack_err_o exists only when PC_STACK_CHECK_EN is defined.
interface pc_stack_if #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
);
    localparam int DW = $clog2(STACK_DEPTH) + 1;

    logic            pc_en_i;
    logic [3:0]      pc_oper_i;
    logic            jsb_i;
    logic            ret_i;
    logic            reti_i;
    logic [PC_W-1:0] addr_i;
    logic [7:0]      disp_i;
    logic            z_i;
    logic            c_i;

    logic [PC_W-1:0] pc_o;
    logic            int_active_o;
    logic            sav_z_o;
    logic            sav_c_o;
    logic            flag_restore_o;
    logic [DW-1:0]   stack_depth_o;
`ifdef PC_STACK_CHECK_EN
    logic            stack_err_o;
`endif

    modport master (
        output pc_en_i, pc_oper_i, jsb_i, ret_i, reti_i,
        output addr_i, disp_i, z_i, c_i,
        input  pc_o, int_active_o, sav_z_o, sav_c_o,
        input  flag_restore_o, stack_depth_o
`ifdef PC_STACK_CHECK_EN
        , input stack_err_o
`endif
    );

    modport slave (
        input  pc_en_i, pc_oper_i, jsb_i, ret_i, reti_i,
        input  addr_i, disp_i, z_i, c_i,
        output pc_o, int_active_o, sav_z_o, sav_c_o,
        output flag_restore_o, stack_depth_o
`ifdef PC_STACK_CHECK_EN
        , output stack_err_o
`endif
    );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: PC sequencer with return stack and one-level interrupt save.
// Define PC_STACK_CHECK_EN for overflow/underflow protection and stack_err_o.
module pc_stack_unit #(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    pc_stack_if.slave bus
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);
    localparam logic [3:0] OP_BZ  = 4'b0100;
    localparam logic [3:0] OP_BNZ = 4'b0101;
    localparam logic [3:0] OP_BC  = 4'b0110;
    localparam logic [3:0] OP_BNC = 4'b0111;
    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_INT = 4'b1100;

    logic [1:0]      rst_q;
    logic            run;
    logic [PC_W-1:0] pc_q, pc_d, spc_q, spc_d;
    logic            int_q, int_d, sz_q, sz_d, sc_q, sc_d;
    logic            fr_q, fr_d;
    logic [AW-1:0]   ptr_q, ptr_d, top_m1;
    logic [DW-1:0]   dep_q, dep_d;
    logic            push, full, empty;
    logic [PC_W-1:0] pc_inc, pc_br;
    logic            en, do_reti, do_ret, do_jsb, do_op;
    logic [PC_W-1:0] mem [STACK_DEPTH];
`ifdef PC_STACK_CHECK_EN
    logic            err_q, err_d;
`endif

    // updates stay blocked until reset release has crossed two clk edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 2'b00;
        else        rst_q <= {rst_q[0], 1'b1};
    end
    assign run = rst_q[1];

    assign en      = run & bus.pc_en_i;
    assign do_reti = en & bus.reti_i;
    assign do_ret  = en & ~bus.reti_i & bus.ret_i;
    assign do_jsb  = en & ~bus.reti_i & ~bus.ret_i & bus.jsb_i;
    assign do_op   = en & ~bus.reti_i & ~bus.ret_i & ~bus.jsb_i;

    assign pc_inc = pc_q + PC_W'(1);
    assign pc_br  = pc_inc + PC_W'($signed(bus.disp_i));
    assign top_m1 = ptr_q - AW'(1);
    assign full   = (dep_q == FULL);
    assign empty  = (dep_q == '0);

    always_comb begin
        pc_d  = pc_q;
        spc_d = spc_q;
        int_d = int_q;
        sz_d  = sz_q;
        sc_d  = sc_q;
        fr_d  = 1'b0;
        ptr_d = ptr_q;
        dep_d = dep_q;
        push  = 1'b0;
`ifdef PC_STACK_CHECK_EN
        err_d = err_q;
`endif
        unique case (1'b1)
            do_reti: begin
                if (int_q) begin
                    pc_d  = spc_q;
                    int_d = 1'b0;
                    fr_d  = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            do_ret: begin
`ifdef PC_STACK_CHECK_EN
                if (empty) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d  = mem[top_m1];
                    ptr_d = top_m1;
                    dep_d = dep_q - DW'(1);
                end
`else
                pc_d  = mem[top_m1];
                ptr_d = top_m1;
                if (!empty) dep_d = dep_q - DW'(1);
`endif
            end
            do_jsb: begin
                pc_d = bus.addr_i;
`ifdef PC_STACK_CHECK_EN
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ptr_d = ptr_q + AW'(1);
                    dep_d = dep_q + DW'(1);
                end
`else
                // ring overwrite: a full push replaces the oldest entry
                push  = 1'b1;
                ptr_d = ptr_q + AW'(1);
                if (!full) dep_d = dep_q + DW'(1);
`endif
            end
            do_op: begin
                case (bus.pc_oper_i)
                    OP_BZ:   pc_d = bus.z_i  ? pc_br : pc_inc;
                    OP_BNZ:  pc_d = !bus.z_i ? pc_br : pc_inc;
                    OP_BC:   pc_d = bus.c_i  ? pc_br : pc_inc;
                    OP_BNC:  pc_d = !bus.c_i ? pc_br : pc_inc;
                    OP_JMP:  pc_d = bus.addr_i;
                    OP_INT: begin
                        if (!int_q) begin
                            spc_d = pc_q;
                            sz_d  = bus.z_i;
                            sc_d  = bus.c_i;
                            pc_d  = PC_W'(1);
                            int_d = 1'b1;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            spc_q <= '0;
            int_q <= 1'b0;
            sz_q  <= 1'b0;
            sc_q  <= 1'b0;
            fr_q  <= 1'b0;
            ptr_q <= '0;
            dep_q <= '0;
        end else begin
            pc_q  <= pc_d;
            spc_q <= spc_d;
            int_q <= int_d;
            sz_q  <= sz_d;
            sc_q  <= sc_d;
            fr_q  <= fr_d;
            ptr_q <= ptr_d;
            dep_q <= dep_d;
        end
    end

`ifdef PC_STACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign bus.stack_err_o = err_q;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[ptr_q] <= pc_inc;
    end

    assign bus.pc_o           = pc_q;
    assign bus.int_active_o   = int_q;
    assign bus.sav_z_o        = sz_q;
    assign bus.sav_c_o        = sc_q;
    assign bus.flag_restore_o = fr_q;
    assign bus.stack_depth_o  = dep_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit.
// Queue-based reference model; directed cases then randomized traffic.
module tb_pc_stack_unit;
    localparam int PC_W = 12;
    localparam int D    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_stack_if #(.PC_W(PC_W), .STACK_DEPTH(D)) bus ();

    pc_stack_unit #(.PC_W(PC_W), .STACK_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [11:0] pc;
        logic        ia;
        logic        sz;
        logic        sc;
        logic        fr;
        logic [3:0]  dep;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] m_pc, m_spc;
    logic        m_int, m_sz, m_sc, m_fr, m_err;
    logic [11:0] m_stk[$];

    function automatic exp_t act();
        exp_t a;
        a.pc  = bus.pc_o;
        a.ia  = bus.int_active_o;
        a.sz  = bus.sav_z_o;
        a.sc  = bus.sav_c_o;
        a.fr  = bus.flag_restore_o;
        a.dep = bus.stack_depth_o;
`ifdef PC_STACK_CHECK_EN
        a.err = bus.stack_err_o;
`else
        a.err = 1'b0;
`endif
        return a;
    endfunction

    function automatic void model_reset();
        m_pc  = '0;
        m_spc = '0;
        m_int = 1'b0;
        m_sz  = 1'b0;
        m_sc  = 1'b0;
        m_fr  = 1'b0;
        m_err = 1'b0;
        m_stk.delete();
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // drive one cycle of inputs and queue the model's view of the result
    task automatic step(input logic en, input logic [3:0] op,
                        input logic j, input logic r, input logic ri,
                        input logic [11:0] a, input logic [7:0] d,
                        input logic z, input logic c);
        exp_t e;
        int   t;
        logic tk;
        @(negedge clk);
        bus.pc_en_i   = en;
        bus.pc_oper_i = op;
        bus.jsb_i     = j;
        bus.ret_i     = r;
        bus.reti_i    = ri;
        bus.addr_i    = a;
        bus.disp_i    = d;
        bus.z_i       = z;
        bus.c_i       = c;
        m_fr = 1'b0;
        if (en) begin
            if (ri) begin
                if (m_int) begin
                    m_pc  = m_spc;
                    m_int = 1'b0;
                    m_fr  = 1'b1;
                end else begin
                    m_pc++;
                end
            end else if (r) begin
                if (m_stk.size() != 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc++;
`ifdef PC_STACK_CHECK_EN
                    m_err = 1'b1;
`endif
                end
            end else if (j) begin
                if (m_stk.size() == D) begin
`ifdef PC_STACK_CHECK_EN
                    m_err = 1'b1;
`else
                    void'(m_stk.pop_front());
                    m_stk.push_back(m_pc + 12'd1);
`endif
                end else begin
                    m_stk.push_back(m_pc + 12'd1);
                end
                m_pc = a;
            end else begin
                case (op)
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        tk = (op == 4'h4) ? z : (op == 4'h5) ? !z :
                             (op == 4'h6) ? c : !c;
                        t = int'(m_pc) + 1 + (tk ? int'($signed(d)) : 0);
                        m_pc = 12'(t & 32'hFFF);
                    end
                    4'h8: m_pc = a;
                    4'hC: begin
                        if (!m_int) begin
                            m_spc = m_pc;
                            m_sz  = z;
                            m_sc  = c;
                            m_pc  = 12'd1;
                            m_int = 1'b1;
                        end else begin
                            m_pc++;
                        end
                    end
                    default: m_pc++;
                endcase
            end
        end
        e.pc  = m_pc;
        e.ia  = m_int;
        e.sz  = m_sz;
        e.sc  = m_sc;
        e.fr  = m_fr;
        e.dep = 4'(m_stk.size());
        e.err = m_err;
        sbq.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic op_step(input logic [3:0] op, input logic [11:0] a,
                           input logic [7:0] d, input logic z,
                           input logic c);
        step(1'b1, op, 1'b0, 1'b0, 1'b0, a, d, z, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        bus.pc_en_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_pc", 32'(bus.pc_o), 32'h0);
        chk("rst_int", 32'(bus.int_active_o), 32'h0);
        chk("rst_fr", 32'(bus.flag_restore_o), 32'h0);
        chk("rst_depth", 32'(bus.stack_depth_o), 32'h0);
        chk("rst_savzc", {30'h0, bus.sav_z_o, bus.sav_c_o}, 32'h0);
`ifdef PC_STACK_CHECK_EN
        chk("rst_err", 32'(bus.stack_err_o), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = act();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb: got pc=%h ia=%b sz=%b sc=%b fr=%b dep=%0d err=%b expected pc=%h ia=%b sz=%b sc=%b fr=%b dep=%0d err=%b",
                             a.pc, a.ia, a.sz, a.sc, a.fr, a.dep, a.err,
                             e.pc, e.ia, e.sz, e.sc, e.fr, e.dep, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] ops [8];
        logic [3:0] op;
        logic       en, r, j, ri;
        int         k;
        ops = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'h0};
        bus.pc_en_i = 1'b0;
        bus.pc_oper_i = 4'h0;
        bus.jsb_i = 1'b0;
        bus.ret_i = 1'b0;
        bus.reti_i = 1'b0;
        bus.addr_i = '0;
        bus.disp_i = '0;
        bus.z_i = 1'b0;
        bus.c_i = 1'b0;
        model_reset();
        #12;
        chk("init_pc", 32'(bus.pc_o), 32'h0);
        chk("init_depth", 32'(bus.stack_depth_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();

        for (int i = 1; i <= 3; i++) begin
            op_step(4'h0, 12'h0, 8'h0, 1'b0, 1'b0);
            settle();
            chk("inc_seq", 32'(bus.pc_o), 32'(i));
        end

        op_step(4'h8, 12'h010, 8'h0, 1'b0, 1'b0);
        op_step(4'h4, 12'h0, 8'hFE, 1'b1, 1'b0);
        settle();
        chk("bz_taken", 32'(bus.pc_o), 32'h00F);
        op_step(4'h8, 12'h010, 8'h0, 1'b0, 1'b0);
        op_step(4'h4, 12'h0, 8'hFE, 1'b0, 1'b0);
        settle();
        chk("bz_not", 32'(bus.pc_o), 32'h011);

        op_step(4'h8, 12'h020, 8'h0, 1'b0, 1'b0);
        step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 12'h300, 8'h0, 1'b0, 1'b0);
        settle();
        chk("jsb_pc", 32'(bus.pc_o), 32'h300);
        chk("jsb_depth", 32'(bus.stack_depth_o), 32'h1);
        step(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
        settle();
        chk("ret_pc", 32'(bus.pc_o), 32'h021);
        chk("ret_depth", 32'(bus.stack_depth_o), 32'h0);

        op_step(4'h8, 12'h055, 8'h0, 1'b0, 1'b0);
        op_step(4'hC, 12'h0, 8'h0, 1'b1, 1'b0);
        settle();
        chk("int_pc", 32'(bus.pc_o), 32'h001);
        chk("int_act", 32'(bus.int_active_o), 32'h1);
        step(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 12'h0, 8'h0, 1'b0, 1'b1);
        settle();
        chk("reti_pc", 32'(bus.pc_o), 32'h055);
        chk("reti_fr", 32'(bus.flag_restore_o), 32'h1);
        chk("reti_sav", {30'h0, bus.sav_z_o, bus.sav_c_o}, 32'h2);
        idle();
        settle();
        chk("fr_pulse_end", 32'(bus.flag_restore_o), 32'h0);

        op_step(4'h8, 12'h100, 8'h0, 1'b0, 1'b0);
        for (int p = 1; p <= 9; p++) begin
            step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 12'(32'h100 + p * 16),
                 8'h0, 1'b0, 1'b0);
            settle();
`ifdef PC_STACK_CHECK_EN
            chk("push_err", 32'(bus.stack_err_o), 32'(p == 9));
`endif
        end
        chk("full_depth", 32'(bus.stack_depth_o), 32'd8);
`ifdef PC_STACK_CHECK_EN
        for (int p = 8; p >= 1; p--) begin
            step(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
            settle();
            chk("pop_lifo", 32'(bus.pc_o), 32'h100 + (p - 1) * 16 + 1);
        end
        for (int p = 0; p < 2; p++) begin
            step(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
            settle();
            chk("underflow_pc", 32'(bus.pc_o), 32'h102 + p);
            chk("underflow_err", 32'(bus.stack_err_o), 32'h1);
        end
`else
        for (int p = 9; p >= 2; p--) begin
            step(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 12'h0, 8'h0, 1'b0, 1'b0);
            settle();
            chk("pop_ring", 32'(bus.pc_o), 32'h100 + (p - 1) * 16 + 1);
        end
`endif
        chk("empty_depth", 32'(bus.stack_depth_o), 32'h0);

        op_step(4'h8, 12'hFFF, 8'h0, 1'b0, 1'b0);
        op_step(4'h0, 12'h0, 8'h0, 1'b0, 1'b0);
        settle();
        chk("pc_wrap", 32'(bus.pc_o), 32'h000);
        op_step(4'hC, 12'h0, 8'h0, 1'b1, 1'b1);
        settle();
        chk("int_again", 32'(bus.int_active_o), 32'h1);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            en = ($urandom_range(0, 9) != 0);
            k  = $urandom_range(0, 99);
            ri = (k < 8);
            r  = (k < 22) && ((k >= 8) || ($urandom_range(0, 1) == 1));
            j  = (k < 36) && ((k >= 22) || ($urandom_range(0, 1) == 1));
`ifndef PC_STACK_CHECK_EN
            if (r && !ri && m_stk.size() == 0) r = 1'b0;
`endif
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            step(en, op, j, r, ri, 12'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
